// File: rtl/gh_pkg.sv
// Shared types and widths for the guitar-hero note judge.
// streak_mult() maps a streak to its multiplier tier (used when STREAK_MULT_EN is defined).
package gh_pkg;
    localparam int NOTE_W   = 5;
    localparam int SCORE_W  = 16;
    localparam int STREAK_W = 8;
    localparam int MULT_MAX = 4;
    localparam int MULT_W   = 3;
    localparam int CNT_W    = 25;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WINDOW,
        ST_HIT,
        ST_MISS
    } judge_state_e;

    // One tier per 8 consecutive hits, capped at MULT_MAX.
    function automatic logic [MULT_W-1:0] streak_mult(input logic [STREAK_W-1:0] streak_v);
        logic [STREAK_W-4:0] tier;
        tier = streak_v[STREAK_W-1:3];
        if (tier >= (STREAK_W-3)'(MULT_MAX - 1)) return MULT_W'(MULT_MAX);
        return MULT_W'(tier) + MULT_W'(1);
    endfunction
endpackage

// File: rtl/strum_sync.sv
// Brings the raw strum switch into the clock domain and emits a one-cycle rising-edge pulse.
// The pulse appears three clocks after the switch rises (two sync flops plus the edge register).
module strum_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic strum,
    output logic strum_rise
);
    logic meta_q, sync_q, last_q, rise_q;
    logic meta_d, sync_d, last_d, rise_d;

    always_comb begin
        meta_d = strum;
        sync_d = meta_q;
        last_d = sync_q;
        rise_d = sync_q & ~last_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            last_q <= 1'b0;
            rise_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            last_q <= last_d;
            rise_q <= rise_d;
        end
    end

    assign strum_rise = rise_q;
endmodule

// File: rtl/hit_judge.sv
// Note-hit judge: opens a timing window per chord arrival, judges strums, keeps score and streak.
// Define STREAK_MULT_EN for the streak-based score multiplier; otherwise the multiplier is fixed at 1.
module hit_judge
    import gh_pkg::*;
#(
    parameter logic [CNT_W-1:0] WINDOW_CYCLES = 25'd6578947,
    parameter logic [7:0]       POINTS_BASE   = 8'd10
) (
    input  logic                CLOCK_50,
    input  logic                resetn,
    input  logic                pause,
    input  logic [NOTE_W-1:0]   exp_notes,
    input  logic [NOTE_W-1:0]   frets,
    input  logic                strum,
    output logic [SCORE_W-1:0]  score,
    output logic [STREAK_W-1:0] streak,
    output logic [MULT_W-1:0]   multiplier,
    output logic                note_active,
    output logic                hit_pulse,
    output logic                miss_pulse
);
    localparam logic [CNT_W-1:0] LAST_CNT = WINDOW_CYCLES - CNT_W'(1);
    localparam int PTS_W = 8 + MULT_W;

    judge_state_e        state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [NOTE_W-1:0]   target_q, target_d;
    logic [NOTE_W-1:0]   prev_exp_q, prev_exp_d;
    logic                pending_q, pending_d;
    logic [SCORE_W-1:0]  score_q, score_d;
    logic [STREAK_W-1:0] streak_q, streak_d;

    logic                strum_rise, rise, arrival, fret_ok, do_hit, do_miss;
    logic [MULT_W-1:0]   mult;
    logic [PTS_W-1:0]    pts;
    logic [SCORE_W:0]    score_sum;

    strum_sync u_strum_sync (
        .clk        (CLOCK_50),
        .rst_n      (resetn),
        .strum      (strum),
        .strum_rise (strum_rise)
    );

`ifdef STREAK_MULT_EN
    assign mult = streak_mult(streak_q);
`else
    assign mult = MULT_W'(1);
`endif

    always_comb begin
        rise      = strum_rise & ~pause;
        arrival   = (exp_notes != prev_exp_q) && (exp_notes != '0);
        fret_ok   = (frets == target_q);
        pts       = PTS_W'(POINTS_BASE) * PTS_W'(mult);
        score_sum = (SCORE_W+1)'(score_q) + (SCORE_W+1)'(pts);
    end

    // A new chord that lands while a judgement is being made is parked in
    // target_q with pending_q set, so the window reopens right after HIT/MISS.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        target_d   = target_q;
        prev_exp_d = prev_exp_q;
        pending_d  = pending_q;
        score_d    = score_q;
        streak_d   = streak_q;
        do_hit     = 1'b0;
        do_miss    = 1'b0;

        if (!pause) begin
            prev_exp_d = exp_notes;
            if (arrival) target_d = exp_notes;

            case (state_q)
                ST_IDLE: begin
                    if (rise) begin
                        do_miss = 1'b1;
                    end else if (arrival) begin
                        state_d = ST_WINDOW;
                        cnt_d   = '0;
                    end
                end
                ST_WINDOW: begin
                    if (rise) begin
                        if (fret_ok) do_hit  = 1'b1;
                        else         do_miss = 1'b1;
                    end else if (arrival || cnt_q == LAST_CNT) begin
                        do_miss = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_HIT, ST_MISS: begin
                    pending_d = 1'b0;
                    if (pending_q || arrival) begin
                        state_d = ST_WINDOW;
                        cnt_d   = '0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase

            if (do_hit) begin
                state_d   = ST_HIT;
                pending_d = arrival;
                streak_d  = (streak_q == '1) ? streak_q : streak_q + STREAK_W'(1);
                score_d   = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
            end
            if (do_miss) begin
                state_d   = ST_MISS;
                pending_d = arrival;
                streak_d  = '0;
            end
        end
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            target_q   <= '0;
            prev_exp_q <= '0;
            pending_q  <= 1'b0;
            score_q    <= '0;
            streak_q   <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            target_q   <= target_d;
            prev_exp_q <= prev_exp_d;
            pending_q  <= pending_d;
            score_q    <= score_d;
            streak_q   <= streak_d;
        end
    end

    assign score       = score_q;
    assign streak      = streak_q;
    assign multiplier  = mult;
    assign note_active = (state_q == ST_WINDOW);
    assign hit_pulse   = (state_q == ST_HIT)  && !pause;
    assign miss_pulse  = (state_q == ST_MISS) && !pause;
endmodule

// File: doc/hit_judge.md
HIT_JUDGE -- requirements
Module: hit_judge

Interface
REQ-001 Parameter WINDOW_CYCLES, default 25'd6578947, hit-window length in clocks (half an eighth note).
REQ-002 Parameter POINTS_BASE, default 8'd10, points per hit before multiplier.
REQ-003 CLOCK_50  input  1  system clock; one clock only; all state on its rising edge.
REQ-004 resetn  input  1  reset, asynchronous, active-low.
REQ-005 pause  input  1  high freezes judging; same signal that pauses the note sender.
REQ-006 exp_notes  input  5  expected fret chord from note sender; 0 = no note.
REQ-007 frets  input  5  player fret buttons, active-high, already synchronous to CLOCK_50.
REQ-008 strum  input  1  raw strum switch level, asynchronous.
REQ-009 score  output  16  accumulated score.
REQ-010 streak  output  8  consecutive-hit count.
REQ-011 multiplier  output  3  current multiplier, 1..4.
REQ-012 note_active  output  1  high while a hit window is open.
REQ-013 hit_pulse  output  1  one-cycle pulse per judged hit.
REQ-014 miss_pulse  output  1  one-cycle pulse per miss, wrong chord or overstrum.

Function
REQ-015 Strum path: 2-flop synchroniser plus edge register; strum_rise is high for exactly one cycle, 3 clocks after strum rises.
REQ-016 Note arrival: exp_notes differs from its previous-cycle value and is non-zero; latch exp_notes into target.
REQ-017 Identical back-to-back chords with no intervening 0 are one arrival.
REQ-018 FSM states: IDLE, WINDOW, HIT, MISS; HIT and MISS last one cycle each, then go to IDLE.
REQ-019 IDLE + arrival -> WINDOW; window counter cleared to 0.
REQ-020 WINDOW + strum_rise + frets==target -> HIT.
REQ-021 WINDOW + strum_rise + frets!=target -> MISS.
REQ-022 WINDOW + counter==WINDOW_CYCLES-1 with no strum_rise -> MISS.
REQ-023 WINDOW + arrival in the same cycle as strum_rise: judge the old target first (HIT or MISS), then reopen WINDOW on the next cycle with the new target.
REQ-024 WINDOW + arrival with no strum_rise: current note counts as MISS; WINDOW reopens with the new target and counter 0.
REQ-025 IDLE + strum_rise (overstrum): miss_pulse, streak cleared, score unchanged.
REQ-026 hit_pulse and miss_pulse are asserted in the HIT/MISS cycle; score and streak update on that same edge.
REQ-027 On HIT: streak increments, saturating at 255; score adds POINTS_BASE*multiplier, saturating at 16'hFFFF.
REQ-028 On MISS: streak is set to 0.
REQ-029 Multiplier is computed from streak before the increment.
REQ-030 note_active is high exactly while in WINDOW.
REQ-031 pause high: FSM, counter and arrival tracking hold; strum_rise is ignored; outputs hold; pulses are 0.

Reset
REQ-032 resetn low asynchronously forces: IDLE, counter 0, target 0, previous-exp 0, synchroniser flops 0, score 0, streak 0, multiplier 1, note_active 0, both pulses 0.
REQ-033 Reset mid-window discards the pending note with no pulse.

Configuration
REQ-034 STREAK_MULT_EN defined: multiplier = 1 + min(streak>>3, 3).
REQ-035 STREAK_MULT_EN undefined: multiplier is constant 1; the streak counter is still maintained.

Structure
REQ-036 Package gh_pkg holds the FSM state typedef, NOTE_W=5, SCORE_W=16, STREAK_W=8, MULT_MAX=4.
REQ-037 Sub-module strum_sync holds the synchroniser and rising-edge detect, producing strum_rise.

Verification (bench uses WINDOW_CYCLES=16)
REQ-038 exp_notes 0->5'b00101, frets=00101, strum rises 4 clocks later -> one hit_pulse; score=10; streak=1.
REQ-039 exp_notes=01010, no strum for 16 clocks -> miss_pulse on cycle 17 after arrival; streak=0; score unchanged.
REQ-040 Target 11000, frets=10100, strum -> miss_pulse; streak=0.
REQ-041 STREAK_MULT_EN defined, 9 consecutive hits -> score=8*10+20=100; multiplier=2 after the 8th hit.
REQ-042 Strum while IDLE -> miss_pulse, streak 5->0; pause high during WINDOW freezes the counter, strum ignored, no pulse.
REQ-043 resetn low mid-WINDOW with score=30 -> outputs return to reset values immediately with no pulse.
